// File: rtl/mysystem_pio_pkg.sv
// Shared register map and helpers for the control/status PIO.
// Option: MYSYSTEM_CTRL_PIO_IRQ_EN enables the EDGE/IRQ_MASK registers in the top.
package mysystem_pio_pkg;

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_PULSE    = 3'd1;
    localparam logic [2:0] ADDR_SET      = 3'd2;
    localparam logic [2:0] ADDR_CLEAR    = 3'd3;
    localparam logic [2:0] ADDR_STATUS   = 3'd4;
    localparam logic [2:0] ADDR_EDGE     = 3'd5;
    localparam logic [2:0] ADDR_IRQ_MASK = 3'd6;

    // Bits needed to hold a count from 0 up to pulse_cycles inclusive.
    function automatic int cnt_width(input int pulse_cycles);
        return $clog2(pulse_cycles + 1);
    endfunction

endpackage

// File: rtl/mysystem_pio_sync2.sv
// Two-flop synchroniser for a bank of asynchronous level inputs.
// Latency: 2 clk from input change to dout. Backpressure: none, free-running.
// Reset clears both stages asynchronously.
module mysystem_pio_sync2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= din;
            sync_q <= meta_q;
        end
    end

    assign dout = sync_q;

endmodule

// File: rtl/mysystem_ctrl_pio.sv
// Avalon-MM control/status PIO: level bank with set/clear, self-clearing strobes, synchronised status.
// Latency: zero-wait-state reads; writes take effect after the accepting edge. Backpressure: none.
// Option: MYSYSTEM_CTRL_PIO_IRQ_EN adds EDGE (W1C), IRQ_MASK and a registered irq.
module mysystem_ctrl_pio
    import mysystem_pio_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int IN_WIDTH     = 8,
    parameter int PULSE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic [DATA_WIDTH-1:0] pulse_out,
    input  logic [IN_WIDTH-1:0]   in_port,
    output logic                  irq
);

    localparam int CW = cnt_width(PULSE_CYCLES);

    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wd_data;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] pulse_q;
    logic [CW-1:0]         cnt;
    logic [IN_WIDTH-1:0]   sync_q;
    logic                  unused_wd;

    assign wr_en     = chipselect & ~write_n;
    assign wd_data   = writedata[DATA_WIDTH-1:0];
    assign unused_wd = ^writedata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q <= '0;
        end else if (wr_en) begin
            case (address)
                ADDR_DATA:  data_q <= wd_data;
                ADDR_SET:   data_q <= data_q | wd_data;
                ADDR_CLEAR: data_q <= data_q & ~wd_data;
                default:    data_q <= data_q;
            endcase
        end
    end

    // A nonzero PULSE write restarts the shared count for every active strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pulse_q <= '0;
            cnt     <= '0;
        end else if (wr_en && (address == ADDR_PULSE) && (wd_data != '0)) begin
            pulse_q <= pulse_q | wd_data;
            cnt     <= CW'(PULSE_CYCLES);
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
                pulse_q <= '0;
            end
        end
    end

    mysystem_pio_sync2 #(
        .WIDTH (IN_WIDTH)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (in_port),
        .dout    (sync_q)
    );

`ifdef MYSYSTEM_CTRL_PIO_IRQ_EN
    logic [IN_WIDTH-1:0] wd_in;
    logic [IN_WIDTH-1:0] prev_q;
    logic [IN_WIDTH-1:0] edge_q;
    logic [IN_WIDTH-1:0] mask_q;
    logic [IN_WIDTH-1:0] edge_clr;
    logic                irq_q;

    assign wd_in    = writedata[IN_WIDTH-1:0];
    assign edge_clr = (wr_en && (address == ADDR_EDGE)) ? wd_in : '0;

    // A rising edge in the same cycle as its W1C wins: clear first, then set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q <= '0;
            edge_q <= '0;
            mask_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            prev_q <= sync_q;
            edge_q <= (edge_q & ~edge_clr) | (sync_q & ~prev_q);
            if (wr_en && (address == ADDR_IRQ_MASK)) begin
                mask_q <= wd_in;
            end
            irq_q <= |(edge_q & mask_q);
        end
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA, ADDR_SET, ADDR_CLEAR: readdata[DATA_WIDTH-1:0] = data_q;
            ADDR_PULSE:                      readdata[DATA_WIDTH-1:0] = pulse_q;
            ADDR_STATUS:                     readdata[IN_WIDTH-1:0]   = sync_q;
`ifdef MYSYSTEM_CTRL_PIO_IRQ_EN
            ADDR_EDGE:                       readdata[IN_WIDTH-1:0]   = edge_q;
            ADDR_IRQ_MASK:                   readdata[IN_WIDTH-1:0]   = mask_q;
`endif
            default:                         readdata = '0;
        endcase
    end

    assign out_port  = data_q;
    assign pulse_out = pulse_q;

endmodule

// File: tb/tb_mysystem_ctrl_pio.sv
// Directed and random bench for mysystem_ctrl_pio against a cycle-count reference model.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_mysystem_ctrl_pio;

    localparam int DW = 8;
    localparam int IW = 8;
    localparam int P  = 4;
`ifdef MYSYSTEM_CTRL_PIO_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n;
    logic [2:0]    address;
    logic          chipselect;
    logic          write_n;
    logic [31:0]   writedata;
    logic [31:0]   readdata;
    logic [DW-1:0] out_port;
    logic [DW-1:0] pulse_out;
    logic [IW-1:0] in_port;
    logic          irq;

    mysystem_ctrl_pio #(
        .DATA_WIDTH   (DW),
        .IN_WIDTH     (IW),
        .PULSE_CYCLES (P)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port),
        .pulse_out  (pulse_out),
        .in_port    (in_port),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: registers by meaning, strobe expiry by absolute cycle number,
    // in_port history as the values seen at the last four edges.
    logic [DW-1:0] data_m, pmask;
    logic [IW-1:0] mask_m, edge_m, h1, h2, h3, h4, cur_in;
    logic          irq_m;
    int            cyc, pend;

    task automatic model_reset();
        data_m = '0; pmask = '0; pend = 0;
        mask_m = '0; edge_m = '0; irq_m = 1'b0;
        h1 = '0; h2 = '0; h3 = '0; h4 = '0;
    endtask

    function automatic logic [31:0] exp_rd(input logic [2:0] a);
        case (a)
            3'd0, 3'd2, 3'd3: return 32'(data_m);
            3'd1:             return 32'(pmask);
            3'd4:             return 32'(h2);
            3'd5:             return 32'(edge_m);
            3'd6:             return 32'(mask_m);
            default:          return 32'h0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rchk(input string tag, input logic [2:0] a);
        address = a;
        #1;
        chk(tag, readdata, exp_rd(a));
    endtask

    // One clock with an optional write; model advances at the edge, outputs checked after it.
    task automatic step(input bit w, input logic [2:0] a, input logic [31:0] d);
        logic          irq_nx;
        logic [IW-1:0] clr;
        chipselect = w; write_n = ~w; address = a; writedata = d; in_port = cur_in;
        @(posedge clk);
        cyc++;
        irq_nx = |(edge_m & mask_m);
        h4 = h3; h3 = h2; h2 = h1; h1 = cur_in;
        clr = '0;
        if (w) begin
            case (a)
                3'd0: data_m = d[DW-1:0];
                3'd1: if (d[DW-1:0] != '0) begin
                          pmask = pmask | d[DW-1:0];
                          pend  = cyc + P;
                      end
                3'd2: data_m = data_m | d[DW-1:0];
                3'd3: data_m = data_m & ~d[DW-1:0];
                3'd5: clr = d[IW-1:0];
                3'd6: if (IRQ_EN) mask_m = d[IW-1:0];
                default: ;
            endcase
        end
        if (IRQ_EN) begin
            edge_m = (edge_m & ~clr) | (h3 & ~h4);
            irq_m  = irq_nx;
        end
        if (cyc >= pend) pmask = '0;
        #1;
        chipselect = 1'b0; write_n = 1'b1;
        chk("out_port", 32'(out_port), 32'(data_m));
        chk("pulse_out", 32'(pulse_out), 32'(pmask));
        chk("irq", 32'(irq), 32'(irq_m));
    endtask

    initial begin
        reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1; address = '0;
        writedata = '0; in_port = '0; cur_in = '0; cyc = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        chk("rst_out", 32'(out_port), 32'h0);
        chk("rst_pulse", 32'(pulse_out), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        rchk("rst_rd_data", 3'd0);

        // Level bank
        step(1'b1, 3'd0, 32'hA5);  chk("lvl_data", 32'(out_port), 32'hA5); rchk("lvl_rd0", 3'd0);
        step(1'b1, 3'd2, 32'h0F);  chk("lvl_set", 32'(out_port), 32'hAF);  rchk("lvl_rd2", 3'd2);
        step(1'b1, 3'd3, 32'h81);  chk("lvl_clr", 32'(out_port), 32'h2E);  rchk("lvl_rd3", 3'd3);
        chk("lvl_rd_val", readdata, 32'h2E);

        // Strobe bank: exactly P cycles high
        step(1'b1, 3'd1, 32'h01);
        chk("pls_first", 32'(pulse_out), 32'h01);
        for (int i = 1; i < P; i++) begin
            step(1'b0, 3'd0, 32'h0);
            chk("pls_hold", 32'(pulse_out), 32'h01);
        end
        step(1'b0, 3'd0, 32'h0);
        chk("pls_end", 32'(pulse_out), 32'h00);

        // Second bit added mid-pulse restarts the count
        step(1'b1, 3'd1, 32'h01);
        step(1'b0, 3'd0, 32'h0);
        step(1'b1, 3'd1, 32'h02);
        chk("pls_or", 32'(pulse_out), 32'h03);
        for (int i = 1; i < P; i++) begin
            step(1'b0, 3'd0, 32'h0);
            chk("pls_or_hold", 32'(pulse_out), 32'h03);
        end
        step(1'b0, 3'd0, 32'h0);
        chk("pls_or_end", 32'(pulse_out), 32'h00);

        step(1'b1, 3'd1, 32'h0);
        chk("pls_zero", 32'(pulse_out), 32'h00);
        step(1'b0, 3'd0, 32'h0);
        chk("pls_zero2", 32'(pulse_out), 32'h00);

        // Status sync, edge capture, irq
        step(1'b1, 3'd6, 32'h08);
        cur_in = 8'h08;
        step(1'b0, 3'd0, 32'h0); rchk("st_0clk", 3'd4);
        step(1'b0, 3'd0, 32'h0); rchk("st_2clk", 3'd4);
        chk("st_val", readdata, 32'h08);
        step(1'b0, 3'd0, 32'h0); rchk("edge_3clk", 3'd5);
        chk("edge_val", readdata, IRQ_EN ? 32'h08 : 32'h0);
        chk("irq_not_yet", 32'(irq), 32'h0);
        step(1'b0, 3'd0, 32'h0);
        chk("irq_rise", 32'(irq), IRQ_EN ? 32'h1 : 32'h0);
        rchk("mask_rd", 3'd6);
        step(1'b1, 3'd5, 32'h08); rchk("edge_w1c", 3'd5);
        chk("edge_w1c_val", readdata, 32'h0);
        step(1'b0, 3'd0, 32'h0);
        chk("irq_fall", 32'(irq), 32'h0);

        // Re-arm, then collide a W1C with a fresh rising edge
        cur_in = 8'h00;
        repeat (4) step(1'b0, 3'd0, 32'h0);
        cur_in = 8'h08;
        repeat (4) step(1'b0, 3'd0, 32'h0);
        chk("irq_rearm", 32'(irq), IRQ_EN ? 32'h1 : 32'h0);
        cur_in = 8'h00;
        repeat (4) step(1'b0, 3'd0, 32'h0);
        cur_in = 8'h08;
        step(1'b0, 3'd0, 32'h0);
        step(1'b0, 3'd0, 32'h0);
        step(1'b1, 3'd5, 32'h08); rchk("edge_collide", 3'd5);
        chk("edge_collide_val", readdata, IRQ_EN ? 32'h08 : 32'h0);
        chk("irq_collide", 32'(irq), IRQ_EN ? 32'h1 : 32'h0);
        step(1'b0, 3'd0, 32'h0);
        chk("irq_collide_next", 32'(irq), IRQ_EN ? 32'h1 : 32'h0);
        rchk("addr7", 3'd7);

        // Asynchronous reset in the middle of a pulse
        step(1'b1, 3'd1, 32'h0F);
        step(1'b1, 3'd0, 32'h55);
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("arst_out", 32'(out_port), 32'h0);
        chk("arst_pulse", 32'(pulse_out), 32'h0);
        chk("arst_irq", 32'(irq), 32'h0);
        for (int a = 0; a < 8; a++) rchk("arst_rd", 3'(a));
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        rchk("post_rst_data", 3'd0);
        chk("post_rst_val", readdata, 32'h0);

        // Random register traffic with asynchronous status changes
        for (int n = 0; n < 500; n++) begin
            if ($urandom_range(0, 3) == 0) cur_in = IW'($urandom);
            step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                 ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom);
            rchk("rnd_rd", 3'($urandom_range(0, 7)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mysystem_ctrl_pio.md
# mysystem_ctrl_pio

Parametrised Avalon-MM control/status PIO, the successor to the single-bit start-signal output port. It drives a DATA_WIDTH-bit level output bank with atomic set/clear, and a self-clearing strobe bank for start pulses of fixed width. It also samples an IN_WIDTH-bit status bank from the accelerator through a synchroniser, with rising-edge capture and an optional maskable interrupt. It sits between the HPS/Nios bridge and the accelerator's start/done handshake wires.

## Interface
Parameters:
- DATA_WIDTH, 8: width of out_port and pulse_out, 1..32.
- IN_WIDTH, 8: width of in_port, 1..32.
- PULSE_CYCLES, 4: strobe length in clk cycles, >= 1.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  3  word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data; bits above the register width are ignored.
- readdata  out  32  read data, combinational from address; unused upper bits 0.
- out_port  out  DATA_WIDTH  level outputs.
- pulse_out  out  DATA_WIDTH  strobe outputs.
- in_port  in  IN_WIDTH  asynchronous status inputs.
- irq  out  1  interrupt, active high.

## Operation
A write is chipselect & ~write_n, sampled on rising clk. Reads have zero wait states and no side effects. Register map:
- 0 DATA (R/W): write replaces data_q; read returns data_q; out_port = data_q.
- 1 PULSE (W; read returns pulse_q): a write with nonzero masked data sets pulse_q |= wd and loads cnt = PULSE_CYCLES.
  - Each following cycle with cnt != 0: cnt decrements; when cnt reaches 0, pulse_q clears.
  - A write while pulses are active ORs in the new bits and restarts the count for all active bits.
  - Writing 0 has no effect.
- 2 SET (W; read returns data_q): data_q |= wd.
- 3 CLEAR (W; read returns data_q): data_q &= ~wd.
- 4 STATUS (RO): synchronised in_port, sync_q.
- 5 EDGE (R/W1C): edge_q[i] sets on sync_q[i] rising. A write of 1 clears the bit. If a new edge coincides with the clear in the same cycle, the edge wins and the bit stays 1.
- 6 IRQ_MASK (R/W): mask_q, IN_WIDTH bits.
- 7: reads 0; writes ignored.

irq_q is registered: irq_q <= |(edge_q & mask_q).

Reset values (immediate and asynchronous, aborting any active pulse): data_q, pulse_q, cnt, sync stages, previous-sample register, edge_q, mask_q and irq all 0.

## Timing
- Write accepted at edge k: out_port and pulse_out change after edge k.
- pulse_out is high for exactly PULSE_CYCLES cycles. With PULSE_CYCLES=1 it is a single-cycle strobe.
- in_port -> STATUS readable: 2 clk (2-FF synchroniser).
- in_port rise -> edge_q bit set: 3 clk.
- edge_q set -> irq high: +1 clk.
- Clearing EDGE or the mask drops irq one cycle after the write edge.
- An in_port pulse shorter than 1 clk may be missed; this is not guaranteed to be captured.

## Configuration
- MYSYSTEM_CTRL_PIO_IRQ_EN defined: EDGE, IRQ_MASK and irq are implemented as described.
- MYSYSTEM_CTRL_PIO_IRQ_EN undefined: no edge or mask registers; addresses 5 and 6 read 0 and ignore writes; irq is tied to 0. STATUS and the synchroniser remain.

## Structure
- Shared package mysystem_pio_pkg holds:
  - address localparams ADDR_DATA..ADDR_IRQ_MASK;
  - the counter-width function, clog2(PULSE_CYCLES+1).
- One sub-module, mysystem_pio_sync2: a parametrised-width 2-FF synchroniser with asynchronous active-low reset, instantiated once for in_port.
- Everything else stays in the top module.

## Test plan
- Reset checks: assert reset_n low mid-pulse -> out_port, pulse_out, irq and all readbacks are 0 immediately; after release, reading DATA returns 0.
- Level bank: write DATA=0xA5, then SET 0x0F, then CLEAR 0x81 -> out_port reads 0xA5, 0xAF, 0x2E after the respective edges; reading addresses 0, 2 and 3 returns the same value.
- Strobe bank: with PULSE_CYCLES=4, write PULSE=0x01 -> pulse_out[0] is high for exactly 4 cycles. Writing 0x02 at cycle 2 -> pulse_out=0x03 for 4 more cycles. Writing 0 -> no pulse.
- Status and edge capture: raise in_port[3] -> STATUS bit 3 after 2 clk and EDGE=0x08 after 3 clk. With mask 0x08, irq rises 1 clk later. A W1C of 0x08 -> irq falls next cycle.
- Edge/clear collision: a W1C of EDGE bit 3 in the same cycle a new rising edge is detected on bit 3 -> the bit remains 1 and irq stays high.
- Build with the macro undefined: addresses 5 and 6 read 0 and irq stays 0 under in_port toggling; STATUS still tracks in_port.
